// File: rtl/scalar_reg_host_bridge.sv
// rtl/scalar_reg_host_bridge.sv - byte-stream command bridge driving the scalar register port
//
// Parses command frames arriving on a valid/ready byte stream and turns them
// into single-cycle register writes or register reads. Read data is returned
// MSB first on a valid/ready byte stream. Only one command is in flight at a
// time; in_ready is low while a write commits or a read is being answered.
//
// Frame format: header byte [7:4] opcode, [3:0] address.
//   opcode 0x1 WRITE : header followed by NBYTES data bytes, MSB first
//   opcode 0x2 READ  : header only; NBYTES response bytes follow on out_*
//   anything else    : one-cycle err pulse, frame dropped
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready/in_data     command byte stream
//   out_valid/out_ready/out_data  response byte stream
//   we/write_addr/write_data      single-cycle register write strobe
//   read_addr/read_data           register read (read_data combinational)
//   err                           one-cycle protocol/address error pulse

module scalar_reg_host_bridge #(
  parameter int WIDTH       = 16,
  parameter int NUM_SCALARS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [7:0]                     in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [7:0]                     out_data,
  output logic                           we,
  output logic [3:0]                     write_addr,
  output logic [WIDTH-1:0]               write_data,
  output logic [$clog2(NUM_SCALARS)-1:0] read_addr,
  input  logic [WIDTH-1:0]               read_data,
  output logic                           err
);

  localparam int NBYTES = WIDTH / 8;
  localparam int AW     = $clog2(NUM_SCALARS);
  localparam int CW     = $clog2(NBYTES + 1);

  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_WCOMMIT,
    S_RLAT,
    S_RRESP
  } state_t;

  state_t          state;
  logic [3:0]      hdr_addr;
  logic [CW-1:0]   cnt;
  // Shared between write-data assembly and read-response serialisation;
  // the two uses never overlap because only one frame is in flight.
  logic [WIDTH-1:0] shreg;

  logic             in_fire;
  logic             out_fire;
  logic             addr_ok;
  logic             last_byte;
  logic [WIDTH-1:0] shreg_in;
  logic [WIDTH-1:0] shreg_shl;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  // Full 4-bit header address is range checked, so aliases above
  // NUM_SCALARS-1 are rejected rather than wrapped.
  assign addr_ok   = ({28'd0, hdr_addr} < NUM_SCALARS);
  assign last_byte = (cnt == CW'(NBYTES - 1));
  assign shreg_in  = (shreg << 8) | WIDTH'(in_data);
  assign shreg_shl = shreg << 8;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      we         <= 1'b0;
      write_addr <= 4'h0;
      write_data <= '0;
      read_addr  <= '0;
      err        <= 1'b0;
      hdr_addr   <= 4'h0;
      cnt        <= '0;
      shreg      <= '0;
    end else begin
      // Strobes are single-cycle by construction.
      we  <= 1'b0;
      err <= 1'b0;

      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            hdr_addr <= in_data[3:0];
            cnt      <= '0;
            case (in_data[7:4])
              OP_WRITE: state <= S_WDATA;
              OP_READ: begin
                state     <= S_RLAT;
                in_ready  <= 1'b0;
                read_addr <= in_data[AW-1:0];
              end
              default: err <= 1'b1;
            endcase
          end
        end

        S_WDATA: begin
          if (in_fire) begin
            shreg <= shreg_in;
            cnt   <= cnt + CW'(1);
            if (last_byte) begin
              // Commit is registered here so we is high during WCOMMIT.
              state    <= S_WCOMMIT;
              in_ready <= 1'b0;
              if (addr_ok) begin
                we         <= 1'b1;
                write_addr <= hdr_addr;
                write_data <= shreg_in;
              end else begin
                err <= 1'b1;
              end
            end
          end
        end

        S_WCOMMIT: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end

        S_RLAT: begin
          // read_addr has been stable for a full cycle; sample the register.
          shreg     <= addr_ok ? read_data : '0;
          out_data  <= addr_ok ? read_data[WIDTH-1 -: 8] : 8'h00;
          out_valid <= 1'b1;
          err       <= !addr_ok;
          cnt       <= '0;
          state     <= S_RRESP;
        end

        S_RRESP: begin
          // out_data only moves on acceptance, so it is held while stalled.
          if (out_fire) begin
            shreg <= shreg_shl;
            cnt   <= cnt + CW'(1);
            if (last_byte) begin
              out_valid <= 1'b0;
              out_data  <= 8'h00;
              state     <= S_IDLE;
              in_ready  <= 1'b1;
            end else begin
              out_data <= shreg_shl[WIDTH-1 -: 8];
            end
          end
        end

        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
